cv32e40p_trace_fifo: RTL and testbench
======================================

CV32E40P_TRACE_FIFO -- requirements
Module: cv32e40p_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-002 Parameter CNT_W, default 32: width of each class counter and of the drop counter.
REQ-003 Parameter SEQ_W, default 16: width of the sequence number.
REQ-004 clk  in  1  Single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  Reset, asynchronous and active-low.
REQ-006 enable_i  in  1  Tracing enable; when low, retires are ignored entirely.
REQ-007 clear_i  in  1  Synchronous clear of class counters, drop counter and sequence number.
REQ-008 retire_valid_i  in  1  One instruction retired this cycle.
REQ-009 retire_pc_i  in  32  PC of the retired instruction.
REQ-010 retire_instr_i  in  32  Uncompressed instruction word.
REQ-011 trace_valid_o  out  1  FIFO head is valid.
REQ-012 trace_ready_i  in  1  Consumer accepts the head.
REQ-013 trace_pc_o  out  32  PC at the head.
REQ-014 trace_instr_o  out  32  Instruction at the head.
REQ-015 trace_class_o  out  4  Instruction class at the head (trace_class_e).
REQ-016 trace_seq_o  out  SEQ_W  Sequence number at the head.
REQ-017 class_cnt_o  out  12*CNT_W  Packed per-class retire counters, class 0 in the LSBs.
REQ-018 drop_cnt_o  out  CNT_W  Count of retires lost to a full FIFO.
REQ-019 full_o  out  1  FIFO holds DEPTH entries.

Function
REQ-020 A retire event SHALL be retire_valid_i & enable_i.
REQ-021 Classification SHALL be combinational on opcode[6:0], funct3 and funct7: LUI/AUIPC/OPIMM/OP base -> ALU(0); BRANCH -> BRANCH(1); JAL/JALR -> JUMP(2); LOAD -> LOAD(3); STORE -> STORE(4); SYSTEM with funct3!=0 -> CSR(5); SYSTEM with funct3==0 -> SYS(6); OP with funct7=0000001 or 0100001 -> MULDIV(7); OP_FP/FMADD/FMSUB/FNMSUB/FNMADD -> FP(8); AMO -> AMO(9); PULP_OP, or OP with funct7 in {0000010,0000100,0001000,0001010} or funct7[6:5]=1x -> PULP(10); anything else -> OTHER(11).
REQ-022 Each retire event SHALL increment that class's counter by 1, saturating at all-ones, regardless of FIFO state.
REQ-023 Each retire event SHALL be stamped with the current sequence number; the sequence number SHALL then increment, wrapping modulo 2^SEQ_W, whether the entry is pushed or dropped, so that gaps in trace_seq_o reveal drops.
REQ-024 A pop SHALL occur when trace_valid_o & trace_ready_i.
REQ-025 A retire event SHALL be pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-026 Otherwise the retire event SHALL be dropped and drop_cnt_o incremented, saturating.
REQ-027 Latency: an entry pushed into an empty FIFO SHALL appear on trace_valid_o and the head outputs in the next cycle; there is no combinational path from retire_* to trace_*.
REQ-028 Head outputs SHALL hold stable while trace_valid_o=1 and trace_ready_i=0.
REQ-029 trace_valid_o SHALL equal !empty; when empty, the head data outputs are don't-care.
REQ-030 The read and write pointers SHALL be log2(DEPTH)+1 bits; full and empty are derived from MSB and index comparison, and wrap-around is seamless.
REQ-031 clear_i SHALL zero the class counters, drop_cnt_o and the sequence number; clear takes priority over a simultaneous increment, and FIFO contents are unaffected.
REQ-032 A retire event in the same cycle as clear_i SHALL still be pushed if space allows, with sequence number 0; the next event then gets 1.
REQ-033 enable_i low SHALL NOT block pops.

Reset
REQ-034 On rst_n low the pointers, counters and sequence number SHALL be zero: trace_valid_o=0, full_o=0, class_cnt_o=0, drop_cnt_o=0.
REQ-035 Reset asserted mid-operation SHALL discard all FIFO contents immediately; storage array contents need no reset.

Structure
REQ-036 trace_class_e (4-bit enum, 12 values) and the classify function SHALL live in cv32e40p_tracer_pkg; opcode constants are taken from cv32e40p_pkg.
REQ-037 The FIFO storage and pointers SHALL be one sub-module, cv32e40p_trace_fifo_mem, parametrised by DEPTH and entry width.

Verification
REQ-038 Reset, then retire addi (0x00100093) at PC 0x80 -> one cycle later: trace_valid_o=1, class=0, seq=0; class_cnt[0]=1.
REQ-039 DEPTH=8 with trace_ready_i=0, 10 consecutive retires -> full_o=1 after the 8th; drop_cnt_o=2; head seq=0; after draining, seqs are 0..7 and the next retire gets seq 10.
REQ-040 FIFO full, retire and pop in the same cycle -> entry pushed, drop_cnt_o unchanged, occupancy stays 8.
REQ-041 Retire mul (0x02208033), lw, fadd.s and p.clip in turn -> class 7, 3, 8, 10 respectively; the corresponding counters each read 1.
REQ-042 clear_i together with a retire -> counters read 0 except the new class, which reads 0 (clear wins); the entry is pushed with seq 0.
REQ-043 SEQ_W=4, 17 retires drained -> seq wraps 15 to 0; rst_n pulsed while 3 entries are queued -> trace_valid_o=0 on the next cycle.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Core-wide constants shared by the tracer.
// Provides the RV32 / PULP major opcode encodings.
package cv32e40p_pkg;

  localparam logic [6:0] OPCODE_SYSTEM    = 7'h73;
  localparam logic [6:0] OPCODE_FENCE     = 7'h0f;
  localparam logic [6:0] OPCODE_OP        = 7'h33;
  localparam logic [6:0] OPCODE_OPIMM     = 7'h13;
  localparam logic [6:0] OPCODE_STORE     = 7'h23;
  localparam logic [6:0] OPCODE_LOAD      = 7'h03;
  localparam logic [6:0] OPCODE_BRANCH    = 7'h63;
  localparam logic [6:0] OPCODE_JALR      = 7'h67;
  localparam logic [6:0] OPCODE_JAL       = 7'h6f;
  localparam logic [6:0] OPCODE_AUIPC     = 7'h17;
  localparam logic [6:0] OPCODE_LUI       = 7'h37;
  localparam logic [6:0] OPCODE_OP_FP     = 7'h53;
  localparam logic [6:0] OPCODE_OP_FMADD  = 7'h43;
  localparam logic [6:0] OPCODE_OP_FNMADD = 7'h4f;
  localparam logic [6:0] OPCODE_OP_FMSUB  = 7'h47;
  localparam logic [6:0] OPCODE_OP_FNMSUB = 7'h4b;
  localparam logic [6:0] OPCODE_AMO       = 7'h2f;
  localparam logic [6:0] OPCODE_PULP_OP   = 7'h5b;

endpackage

// File: rtl/cv32e40p_tracer_pkg.sv
// Trace instruction classes and the retire classifier.
// classify() maps an uncompressed instruction word to trace_class_e.
package cv32e40p_tracer_pkg;

  import cv32e40p_pkg::*;

  localparam int NUM_CLASSES = 12;

  typedef enum logic [3:0] {
    TC_ALU    = 4'd0,
    TC_BRANCH = 4'd1,
    TC_JUMP   = 4'd2,
    TC_LOAD   = 4'd3,
    TC_STORE  = 4'd4,
    TC_CSR    = 4'd5,
    TC_SYS    = 4'd6,
    TC_MULDIV = 4'd7,
    TC_FP     = 4'd8,
    TC_AMO    = 4'd9,
    TC_PULP   = 4'd10,
    TC_OTHER  = 4'd11
  } trace_class_e;

  // Register-register ops share OPCODE_OP; funct7 selects the unit.
  function automatic trace_class_e op_class(
    input logic [6:0] f7
  );
    trace_class_e c;
    c = TC_OTHER;
    unique case (1'b1)
      (f7 == 7'b0000000) || (f7 == 7'b0100000): c = TC_ALU;
      (f7 == 7'b0000001) || (f7 == 7'b0100001): c = TC_MULDIV;
      (f7 == 7'b0000010) || (f7 == 7'b0000100) ||
      (f7 == 7'b0001000) || (f7 == 7'b0001010) ||
      f7[6]:                                    c = TC_PULP;
      default:                                  c = TC_OTHER;
    endcase
    return c;
  endfunction

  function automatic trace_class_e classify(
    input logic [31:0] instr
  );
    trace_class_e c;
    logic [6:0] opc;
    logic [2:0] f3;
    opc = instr[6:0];
    f3  = instr[14:12];
    c   = TC_OTHER;
    unique case (opc)
      OPCODE_LUI,
      OPCODE_AUIPC,
      OPCODE_OPIMM:     c = TC_ALU;
      OPCODE_OP:        c = op_class(instr[31:25]);
      OPCODE_BRANCH:    c = TC_BRANCH;
      OPCODE_JAL,
      OPCODE_JALR:      c = TC_JUMP;
      OPCODE_LOAD:      c = TC_LOAD;
      OPCODE_STORE:     c = TC_STORE;
      OPCODE_SYSTEM:    c = (f3 != 3'd0) ? TC_CSR : TC_SYS;
      OPCODE_OP_FP,
      OPCODE_OP_FMADD,
      OPCODE_OP_FMSUB,
      OPCODE_OP_FNMSUB,
      OPCODE_OP_FNMADD: c = TC_FP;
      OPCODE_AMO:       c = TC_AMO;
      OPCODE_PULP_OP:   c = TC_PULP;
      default:          c = TC_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cv32e40p_trace_fifo_mem.sv
// Storage and pointers of the trace FIFO (DEPTH x WIDTH).
// Ports: push_i/pop_i/wdata_i in; rdata_o head, empty_o, full_o out.
module cv32e40p_trace_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign wptr_d = push_i ? wptr_q + PTR_ONE : wptr_q;
  assign rptr_d = pop_i  ? rptr_q + PTR_ONE : rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Push on full with pop writes the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/cv32e40p_trace_fifo.sv
// Retire trace FIFO with per-class counters, drop count and seq stamps.
// In: retire_*, enable/clear, trace_ready. Out: trace head, counters, full.
module cv32e40p_trace_fifo
  import cv32e40p_tracer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  retire_valid_i,
  input  logic [31:0]           retire_pc_i,
  input  logic [31:0]           retire_instr_i,
  output logic                  trace_valid_o,
  input  logic                  trace_ready_i,
  output logic [31:0]           trace_pc_o,
  output logic [31:0]           trace_instr_o,
  output logic [3:0]            trace_class_o,
  output logic [SEQ_W-1:0]      trace_seq_o,
  output logic [12*CNT_W-1:0]   class_cnt_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic                  full_o
);

  localparam int unsigned EW = 32 + 32 + 4 + SEQ_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [SEQ_W-1:0] SEQ_ONE = 1;

  logic             evt, pop, push, drop;
  logic             empty, full;
  trace_class_e     cls;
  logic [SEQ_W-1:0] seq_q, seq_d, stamp;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [EW-1:0]    wdata, rdata;

  assign evt  = retire_valid_i & enable_i;
  assign cls  = classify(retire_instr_i);
  assign pop  = trace_valid_o & trace_ready_i;
  assign push = evt & (~full | pop);
  assign drop = evt & ~push;

  // A clearing cycle restarts numbering at the event it carries.
  assign stamp = clear_i ? '0 : seq_q;
  assign seq_d = evt ? stamp + SEQ_ONE : stamp;

  assign wdata = {retire_pc_i, retire_instr_i, cls, stamp};

  cv32e40p_trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .empty_o (empty),
    .full_o  (full)
  );

  assign {trace_pc_o, trace_instr_o, trace_class_o, trace_seq_o} = rdata;
  assign trace_valid_o = ~empty;
  assign full_o        = full;

  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i)
        cnt_d[i] = '0;
      else if (evt && (cls == trace_class_e'(i)) && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + CNT_ONE;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (clear_i)
      drop_d = '0;
    else if (drop && (drop_q != '1))
      drop_d = drop_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= '0;
      drop_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      seq_q  <= seq_d;
      drop_q <= drop_d;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    assign class_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cv32e40p_trace_fifo.sv
// Directed bench for cv32e40p_trace_fifo (DEPTH 8, 4-bit counters/seq).
// Expected values are hand-computed per step.
module tb_cv32e40p_trace_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int SEQ_W = 4;

  logic               clk;
  logic               rst_n;
  logic               enable_i;
  logic               clear_i;
  logic               retire_valid_i;
  logic [31:0]        retire_pc_i;
  logic [31:0]        retire_instr_i;
  logic               trace_valid_o;
  logic               trace_ready_i;
  logic [31:0]        trace_pc_o;
  logic [31:0]        trace_instr_o;
  logic [3:0]         trace_class_o;
  logic [SEQ_W-1:0]   trace_seq_o;
  logic [12*CNT_W-1:0] class_cnt_o;
  logic [CNT_W-1:0]   drop_cnt_o;
  logic               full_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_trace_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .SEQ_W (SEQ_W)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .clear_i        (clear_i),
    .retire_valid_i (retire_valid_i),
    .retire_pc_i    (retire_pc_i),
    .retire_instr_i (retire_instr_i),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_pc_o     (trace_pc_o),
    .trace_instr_o  (trace_instr_o),
    .trace_class_o  (trace_class_o),
    .trace_seq_o    (trace_seq_o),
    .class_cnt_o    (class_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .full_o         (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int i);
    return class_cnt_o[i*CNT_W +: CNT_W];
  endfunction

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    chk("rst_async_valid", 64'(trace_valid_o), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_cnt", 64'(class_cnt_o), 64'd0);
  endtask

  logic [31:0] tab_ins [20];
  logic [3:0]  tab_cls [20];
  logic [3:0]  drain_seq [8];

  localparam logic [31:0] ADDI = 32'h00100093;

  initial begin
    tab_ins = '{32'h02208033, 32'h00012083, 32'h003100D3, 32'h145110B3,
                32'h00208063, 32'h0000006F, 32'h00008067, 32'h00112023,
                32'h34011073, 32'h00000073, 32'h0000202F, 32'h0000005B,
                32'h0000000B, 32'h40208033, 32'h06208033, 32'h80208033,
                32'h00000043, 32'h0000000F, 32'h000000B7, 32'h42208033};
    tab_cls = '{4'd7, 4'd3, 4'd8, 4'd10, 4'd1, 4'd2, 4'd2, 4'd4,
                4'd5, 4'd6, 4'd9, 4'd10, 4'd11, 4'd0, 4'd11, 4'd10,
                4'd8, 4'd11, 4'd0, 4'd7};
    drain_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};

    rst_n = 1'b0;
    enable_i = 1'b1;
    clear_i = 1'b0;
    retire_valid_i = 1'b0;
    retire_pc_i = '0;
    retire_instr_i = '0;
    trace_ready_i = 1'b0;
    tick();
    tick();
    chk("reset_valid", 64'(trace_valid_o), 64'd0);
    chk("reset_full", 64'(full_o), 64'd0);
    chk("reset_cnt", 64'(class_cnt_o), 64'd0);
    chk("reset_drop", 64'(drop_cnt_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // First retire: one-cycle latency to head.
    retire_valid_i = 1'b1;
    retire_pc_i = 32'h80;
    retire_instr_i = ADDI;
    tick();
    retire_valid_i = 1'b0;
    chk("first_valid", 64'(trace_valid_o), 64'd1);
    chk("first_class", 64'(trace_class_o), 64'd0);
    chk("first_seq", 64'(trace_seq_o), 64'd0);
    chk("first_pc", 64'(trace_pc_o), 64'h80);
    chk("first_instr", 64'(trace_instr_o), 64'(ADDI));
    chk("first_cnt0", 64'(cnt(0)), 64'd1);
    trace_ready_i = 1'b1;
    tick();
    trace_ready_i = 1'b0;
    chk("first_pop_empty", 64'(trace_valid_o), 64'd0);

    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear_cnt", 64'(class_cnt_o), 64'd0);

    // Overflow: 10 retires into 8 entries.
    for (int i = 0; i < 10; i++) begin
      retire_valid_i = 1'b1;
      retire_pc_i = 32'h100 + 32'(4 * i);
      retire_instr_i = ADDI;
      tick();
      if (i == 6) chk("full_after7", 64'(full_o), 64'd0);
      if (i == 7) chk("full_after8", 64'(full_o), 64'd1);
    end
    retire_valid_i = 1'b0;
    chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
    chk("ovf_head_seq", 64'(trace_seq_o), 64'd0);
    chk("ovf_head_pc", 64'(trace_pc_o), 64'h100);
    chk("ovf_cnt0", 64'(cnt(0)), 64'd10);

    // Retire and pop together while full.
    retire_valid_i = 1'b1;
    retire_pc_i = 32'h200;
    trace_ready_i = 1'b1;
    tick();
    retire_valid_i = 1'b0;
    chk("fullpp_full", 64'(full_o), 64'd1);
    chk("fullpp_drop", 64'(drop_cnt_o), 64'd2);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_seq%0d", k), 64'(trace_seq_o),
          64'(drain_seq[k]));
      if (k == 7) chk("drain_last_pc", 64'(trace_pc_o), 64'h200);
      tick();
    end
    trace_ready_i = 1'b0;
    chk("drain_empty", 64'(trace_valid_o), 64'd0);

    // Classification table.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int j = 0; j < 20; j++) begin
      retire_valid_i = 1'b1;
      retire_instr_i = tab_ins[j];
      tick();
      retire_valid_i = 1'b0;
      chk($sformatf("class_%0h", tab_ins[j]), 64'(trace_class_o),
          64'(tab_cls[j]));
      trace_ready_i = 1'b1;
      tick();
      trace_ready_i = 1'b0;
      if (j == 3) begin
        chk("cnt_mul", 64'(cnt(7)), 64'd1);
        chk("cnt_lw", 64'(cnt(3)), 64'd1);
        chk("cnt_fadd", 64'(cnt(8)), 64'd1);
        chk("cnt_clip", 64'(cnt(10)), 64'd1);
        chk("cnt_alu0", 64'(cnt(0)), 64'd0);
      end
    end
    chk("cnt_pulp", 64'(cnt(10)), 64'd3);
    chk("cnt_other", 64'(cnt(11)), 64'd3);
    chk("cnt_jump", 64'(cnt(2)), 64'd2);
    chk("cnt_muldiv", 64'(cnt(7)), 64'd2);

    // Clear together with a retire.
    clear_i = 1'b1;
    retire_valid_i = 1'b1;
    retire_instr_i = ADDI;
    tick();
    clear_i = 1'b0;
    chk("clr_evt_cnt", 64'(class_cnt_o), 64'd0);
    chk("clr_evt_valid", 64'(trace_valid_o), 64'd1);
    chk("clr_evt_seq", 64'(trace_seq_o), 64'd0);
    tick();
    retire_valid_i = 1'b0;
    chk("clr_next_cnt0", 64'(cnt(0)), 64'd1);
    trace_ready_i = 1'b1;
    tick();
    chk("clr_next_seq", 64'(trace_seq_o), 64'd1);
    tick();
    trace_ready_i = 1'b0;
    chk("clr_drained", 64'(trace_valid_o), 64'd0);

    // Streaming 17 retires: seq wraps, class counter saturates.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    trace_ready_i = 1'b1;
    retire_valid_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk($sformatf("wrap_seq%0d", k), 64'(trace_seq_o), 64'(k % 16));
    end
    retire_valid_i = 1'b0;
    tick();
    trace_ready_i = 1'b0;
    chk("wrap_empty", 64'(trace_valid_o), 64'd0);
    chk("cnt_sat", 64'(cnt(0)), 64'd15);

    // Drop counter saturation.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    retire_valid_i = 1'b1;
    for (int k = 0; k < 24; k++) tick();
    retire_valid_i = 1'b0;
    chk("drop_sat", 64'(drop_cnt_o), 64'd15);
    chk("drop_full", 64'(full_o), 64'd1);
    rst_pulse();

    // Reset with 3 entries queued.
    retire_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    retire_valid_i = 1'b0;
    chk("q3_valid", 64'(trace_valid_o), 64'd1);
    chk("q3_cnt0", 64'(cnt(0)), 64'd3);
    rst_pulse();

    // Disabled retires are ignored, pops still work.
    enable_i = 1'b0;
    retire_valid_i = 1'b1;
    tick();
    chk("dis_valid", 64'(trace_valid_o), 64'd0);
    chk("dis_cnt0", 64'(cnt(0)), 64'd0);
    enable_i = 1'b1;
    tick();
    tick();
    enable_i = 1'b0;
    trace_ready_i = 1'b1;
    tick();
    chk("dis_pop_valid", 64'(trace_valid_o), 64'd1);
    chk("dis_pop_seq", 64'(trace_seq_o), 64'd1);
    tick();
    chk("dis_pop_empty", 64'(trace_valid_o), 64'd0);
    chk("dis_cnt_final", 64'(cnt(0)), 64'd2);
    retire_valid_i = 1'b0;
    trace_ready_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
